// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared Mult/Div resource: latches operands, starts the selected unit,
// waits for its stop flag (bounded by a timeout), then commits HI/LO and reports status.
module muldiv_sequencer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_sel,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic             start_multi,
    input  logic             stop_multi,
    output logic             start_div,
    input  logic             stop_div,
    output logic             hi_write,
    output logic             lo_write,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXC,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               stop_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Only the stop flag of the unit that was actually launched is honoured.
    assign stop_sel = sel_q ? stop_div : stop_multi;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    a_d   = a_in;
                    b_d   = b_in;
                    sel_d = op_sel;
                    if (op_sel && (b_in == '0)) begin
                        state_d = S_EXC;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_EXC: begin
                state_d = S_IDLE;
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (stop_sel) begin
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // The timeout pulse is emitted from a flop while already back in IDLE.
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start_multi = (state_q == S_LAUNCH) && !sel_q;
        start_div   = (state_q == S_LAUNCH) && sel_q;
        hi_write    = (state_q == S_WRITE);
        lo_write    = (state_q == S_WRITE);
        done        = (state_q == S_DONE);
        div_zero    = (state_q == S_EXC);
        busy        = (state_q != S_IDLE);
        timeout     = timeout_q;
        unit_a      = a_q;
        unit_b      = b_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver predicts the cycle and kind of every
// output pulse from the operation rules; an independent monitor matches what the DUT emits.
module tb_muldiv_sequencer;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 40;
    localparam int CNT_W   = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             op_start;
    logic             op_sel;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] unit_a;
    logic [WIDTH-1:0] unit_b;
    logic             start_multi;
    logic             stop_multi;
    logic             start_div;
    logic             stop_div;
    logic             hi_write;
    logic             lo_write;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             timeout;

    // Pulse vector order: {start_multi, start_div, hi_write, lo_write, done, div_zero, timeout}
    typedef struct {
        int               cyc;
        logic [6:0]       vec;
        logic             busy;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] mon_vec;

    muldiv_sequencer #(
        .WIDTH(WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .op_start(op_start),
        .op_sel(op_sel),
        .a_in(a_in),
        .b_in(b_in),
        .unit_a(unit_a),
        .unit_b(unit_b),
        .start_multi(start_multi),
        .stop_multi(stop_multi),
        .start_div(start_div),
        .stop_div(stop_div),
        .hi_write(hi_write),
        .lo_write(lo_write),
        .busy(busy),
        .done(done),
        .div_zero(div_zero),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every pulse the DUT emits must match the oldest outstanding prediction.
    always @(negedge clock) begin
        if (!reset) begin
            mon_vec = {start_multi, start_div, hi_write, lo_write, done, div_zero, timeout};
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL missing_event: cycle %0d saw nothing, required vec=%b at cycle %0d",
                         cyc, exp_q[0].vec, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (mon_vec != 7'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_event: cycle %0d got vec=%b, required none", cyc, mon_vec);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec != mon_vec || e.busy != busy ||
                        e.a != unit_a || e.b != unit_b) begin
                        miscompares++;
                        $display("[TB] FAIL event: got cyc=%0d vec=%b busy=%b a=%h b=%h, required cyc=%0d vec=%b busy=%b a=%h b=%h",
                                 cyc, mon_vec, busy, unit_a, unit_b, e.cyc, e.vec, e.busy, e.a, e.b);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic pushEv(input int c, input logic [6:0] v, input logic bsy,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        ev_t e;
        e.cyc  = c;
        e.vec  = v;
        e.busy = bsy;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    // Issue one operation; n is the WAIT cycle (1-based) in which the selected stop rises,
    // n > TIMEOUT means it never rises. noise adds ignored op_starts and stray stop flags.
    task automatic applyStimulus(input logic sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int n, input bit noise);
        int t0;
        int endc;
        bit exc;
        checkOutput("idle_before_op", {31'b0, busy}, 32'd0);
        t0  = cyc;
        exc = sel && (b == '0);
        op_start = 1'b1;
        op_sel   = sel;
        a_in     = a;
        b_in     = b;
        if (exc) begin
            pushEv(t0 + 1, 7'b0000010, 1'b1, a, b);
            endc = 1;
        end else begin
            pushEv(t0 + 1, sel ? 7'b0100000 : 7'b1000000, 1'b1, a, b);
            if (n <= TIMEOUT) begin
                pushEv(t0 + n + 2, 7'b0011000, 1'b1, a, b);
                pushEv(t0 + n + 3, 7'b0000100, 1'b1, a, b);
                endc = n + 3;
            end else begin
                pushEv(t0 + TIMEOUT + 2, 7'b0000001, 1'b0, a, b);
                endc = TIMEOUT + 1;
            end
        end
        step();
        for (int c = 1; c <= endc; c++) begin
            op_start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            op_sel     = 1'($urandom_range(0, 1));
            a_in       = $urandom;
            b_in       = $urandom;
            stop_multi = 1'b0;
            stop_div   = 1'b0;
            if (!exc) begin
                if (noise) begin
                    if (sel) stop_multi = 1'($urandom_range(0, 1));
                    else     stop_div   = 1'($urandom_range(0, 1));
                end
                if (c == n + 1 || (noise && c == 1)) begin
                    if (sel) stop_div   = 1'b1;
                    else     stop_multi = 1'b1;
                end
            end
            step();
        end
        op_start   = 1'b0;
        stop_multi = 1'b0;
        stop_div   = 1'b0;
    endtask

    // Reset while the multiply is waiting; only the launch pulse may appear.
    task automatic resetInWait();
        int t0;
        t0       = cyc;
        op_start = 1'b1;
        op_sel   = 1'b0;
        a_in     = 32'h0000_1234;
        b_in     = 32'h0000_0055;
        pushEv(t0 + 1, 7'b1000000, 1'b1, a_in, b_in);
        step();
        op_start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_pulses", {25'b0, start_multi, start_div, hi_write, lo_write, done, div_zero, timeout}, 32'd0);
        checkOutput("rst_unit_a", unit_a, 32'd0);
        checkOutput("rst_unit_b", unit_b, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        op_start   = 1'b0;
        op_sel     = 1'b0;
        a_in       = '0;
        b_in       = '0;
        stop_multi = 1'b0;
        stop_div   = 1'b0;
        step();
        step();
        step();
        checkOutput("por_busy", {31'b0, busy}, 32'd0);
        checkOutput("por_pulses", {25'b0, start_multi, start_div, hi_write, lo_write, done, div_zero, timeout}, 32'd0);
        checkOutput("por_unit_a", unit_a, 32'd0);
        checkOutput("por_unit_b", unit_b, 32'd0);
        reset = 1'b0;
        step();

        applyStimulus(1'b0, 32'd7, 32'd6, 3, 1'b1);
        applyStimulus(1'b1, 32'd100, 32'd0, 3, 1'b0);
        applyStimulus(1'b1, 32'd9, 32'd3, TIMEOUT + 1, 1'b0);
        applyStimulus(1'b1, 32'd9, 32'd3, TIMEOUT, 1'b0);
        applyStimulus(1'b1, 32'd55, 32'd5, 5, 1'b1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        applyStimulus(1'b1, 32'd81, 32'd9, 2, 1'b1);
        resetInWait();
        applyStimulus(1'b0, 32'd7, 32'd6, 3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic             s;
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            int               n;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            n = $urandom_range(1, TIMEOUT + 4);
            applyStimulus(s, a, b, n, 1'b1);
            if ($urandom_range(0, 2) == 0) step();
        end

        repeat (5) step();
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL leftover_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multiply/divide resource for the multicycle CPU and owns the start/stop handshake with the Mult and Div units.
- Accepts one operation request at a time from the control unit and holds the latched operands steady on the unit inputs for the whole operation.
- Commits results to the HI/LO registers, then reports completion, divide-by-zero or timeout back to the control unit.

Parameters:
- WIDTH, 32, operand width.
- TIMEOUT_CYCLES, 40, maximum number of WAIT cycles allowed before the operation is abandoned.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- op_start  in  1  request pulse from the control unit; sampled only in IDLE.
- op_sel  in  1  0 = multiply, 1 = divide; latched with op_start.
- a_in  in  WIDTH  operand A (dividend / multiplicand).
- b_in  in  WIDTH  operand B (divisor / multiplier).
- unit_a  out  WIDTH  latched A, driven to both units.
- unit_b  out  WIDTH  latched B, driven to both units.
- start_multi  out  1  one-cycle start pulse to Mult.
- stop_multi  in  1  completion flag from Mult.
- start_div  out  1  one-cycle start pulse to Div.
- stop_div  in  1  completion flag from Div.
- hi_write  out  1  HI register load enable.
- lo_write  out  1  LO register load enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle success pulse.
- div_zero  out  1  one-cycle divide-by-zero exception pulse.
- timeout  out  1  one-cycle timeout pulse.

Behaviour:
- Reset values: all outputs 0, unit_a/unit_b 0, counter 0, state IDLE.
- Reset mid-operation returns to IDLE on the next edge with no writes and no pulses, regardless of state.
- All outputs are registered/Moore, decoded from state.
- States: IDLE, EXC, LAUNCH, WAIT, WRITE, DONE.
- IDLE, op_start=1: latch a_in, b_in, op_sel.
  - If op_sel=1 and b_in==0: next state EXC.
  - Otherwise: next state LAUNCH.
- IDLE, op_start=0: stay in IDLE.
- op_start outside IDLE is ignored; the latched operands do not change.
- EXC (1 cycle): div_zero=1; no start pulse, no hi/lo write; next state IDLE.
- LAUNCH (1 cycle):
  - start_multi=1 if the latched op_sel=0, otherwise start_div=1.
  - Counter cleared to 0.
  - Next state WAIT.
  - stop inputs are not sampled in this state.
- WAIT:
  - Only the stop input of the selected unit is observed; the other stop input is ignored.
  - Selected stop=1: next state WRITE.
  - Else if counter==TIMEOUT_CYCLES-1: timeout pulse next cycle, then IDLE; no writes.
  - Else: counter+1, stay in WAIT.
  - If stop and the timeout condition occur in the same cycle, stop wins.
  - WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
- WRITE (1 cycle): hi_write=lo_write=1; next state DONE.
- DONE (1 cycle): done=1; next state IDLE. A new op_start is accepted in the first IDLE cycle after DONE.
- Latency (cycle 0 = op_start sampled):
  - LAUNCH in cycle 1, WAIT from cycle 2.
  - If stop is sampled high in cycle k: WRITE in k+1, DONE in k+2.
  - Minimum op_start-to-done latency is 4 cycles.
- Pulse exclusivity: start_*, hi/lo_write, done, div_zero and timeout are mutually exclusive and never overlap in any cycle.
- unit_a/unit_b hold their values from latch until the next accepted op_start.

Test Plan:
- Mult: op_start, op_sel=0, a=7, b=6; stop_multi asserted in the 3rd WAIT cycle -> start_multi high exactly 1 cycle at cycle 1, hi/lo_write at cycle 5, done at cycle 6, unit_a=7, unit_b=6, start_div never high.
- Div by zero: op_sel=1, a=100, b=0 -> div_zero pulse at cycle 1, start_div/hi_write/lo_write/done stay 0, busy low again at cycle 2.
- Timeout: op_sel=1, a=9, b=3, stop_div held 0 -> exactly 40 WAIT cycles, timeout pulse at cycle 42, no hi/lo_write, then IDLE. Variant: stop_div asserted in WAIT cycle 40 -> WRITE, no timeout.
- Ignored inputs:
  - Second op_start (a=1, b=1) while busy -> latched 7/6 unchanged.
  - stop_multi asserted during a div WAIT -> no effect.
  - stop_div high during LAUNCH -> not honoured; the op completes only on a later WAIT-cycle stop.
- Reset in WAIT at cycle 4 -> next cycle all outputs 0, busy=0; a following op_start behaves exactly as from power-on.
- Back-to-back: second op_start on the cycle after DONE -> accepted, new LAUNCH the following cycle.
